// File: rtl/iob_reg_rr_arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package iob_reg_rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    // Index width for an N-entry requester vector, never narrower than 1 bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_reg_rr_arb_if.sv
// Requester-side bus of the round-robin register arbiter.
interface iob_reg_rr_arb_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) ();
    import iob_reg_rr_arb_pkg::*;

    localparam int IDX_W = idx_w(N_REQ);

    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_lock_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [IDX_W-1:0]        grant_idx_o;
    logic                    busy_o;
    logic [DATA_W-1:0]       data_o;
    logic                    update_o;

    modport master (
        output req_valid_i, req_lock_i, req_data_i,
        input  req_ready_o, grant_idx_o, busy_o, data_o, update_o
    );

    modport slave (
        input  req_valid_i, req_lock_i, req_data_i,
        output req_ready_o, grant_idx_o, busy_o, data_o, update_o
    );

endinterface

// File: rtl/iob_reg_r.sv
// Plain register with async reset, clock enable and synchronous clear.
module iob_reg_r #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    // Synchronous clear wins over the incoming value.
    always_comb begin
        data_d = rst_i ? RST_VAL : data_i;
    end

    // Storage, frozen while the clock enable is low.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else if (cke_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/iob_reg_rr_arb_pick.sv
// Rotating-priority picker: first valid index at or after ptr_i, wrapping.
module iob_reg_rr_arb_pick
    import iob_reg_rr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned k;
        logic        hit;
        logic [IDX_W-1:0] sel;
        k   = 0;
        hit = 1'b0;
        sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = (32'(ptr_i) + i) % N_REQ;
            if (!hit && valid_i[IDX_W'(k)]) begin
                hit = 1'b1;
                sel = IDX_W'(k);
            end
        end
        found_o = hit;
        idx_o   = sel;
    end

endmodule

// File: rtl/iob_reg_rr_arb.sv
// Round-robin write arbiter sharing one holding register between N_REQ
// requesters, with locked multi-cycle ownership.
// Optional: define IOB_REG_RR_ARB_TIMEOUT_EN to force-release a locked owner
// after TIMEOUT idle owned cycles.
module iob_reg_rr_arb
    import iob_reg_rr_arb_pkg::*;
#(
    parameter int                N_REQ   = 4,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             cke_i,
    input  logic             rst_i,
    iob_reg_rr_arb_if.slave  bus
);
    localparam int IDX_W = idx_w(N_REQ);

    if (N_REQ < 2 || TIMEOUT < 1) begin : g_cfg_check
        $error("iob_reg_rr_arb: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic             update_q, update_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_next;
    logic             transfer;
    logic [N_REQ-1:0] ready;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_cur;
    logic             arst;

`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    iob_reg_rr_arb_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .valid_i (bus.req_valid_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign ptr_next = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign transfer = (state_q == OWNED) && bus.req_valid_i[grant_q] && cke_i;
    assign data_in  = transfer ? bus.req_data_i[grant_q*DATA_W +: DATA_W] : data_cur;
    assign arst     = ~arst_n_i;

    iob_reg_r #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_data_reg (
        .clk_i  (clk_i),
        .arst_i (arst),
        .cke_i  (cke_i),
        .rst_i  (rst_i),
        .data_i (data_in),
        .data_o (data_cur)
    );

    // Only the current owner sees ready, and only while the clock is enabled.
    always_comb begin
        ready = '0;
        if (state_q == OWNED) begin
            ready[grant_q] = cke_i;
        end
    end

    // Next-state, pointer, grant and strobe; rst_i overrides everything.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        update_d = 1'b0;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = OWNED;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            OWNED: begin
                if (transfer) begin
                    update_d = 1'b1;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                    if (!bus.req_lock_i[grant_q]) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                    end
                end else if (!bus.req_lock_i[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            state_d  = IDLE;
            ptr_d    = '0;
            grant_d  = '0;
            update_d = 1'b0;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
        end
    end

    // Control state registers, frozen while the clock enable is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            update_q <= 1'b0;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else if (cke_i) begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            update_q <= update_d;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.grant_idx_o = grant_q;
    assign bus.busy_o      = (state_q == OWNED);
    assign bus.data_o      = data_cur;
    assign bus.update_o    = update_q;

endmodule

// File: tb/tb_iob_reg_rr_arb.sv
// Self-checking bench for iob_reg_rr_arb: directed scenarios plus random
// traffic, every cycle compared against a behavioural arbiter model.
module tb_iob_reg_rr_arb;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 4;
    localparam logic [W-1:0] RV = 8'hA5;
`ifdef IOB_REG_RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    logic cke    = 1'b1;
    logic rst    = 1'b0;

    always #5 clk = ~clk;

    iob_reg_rr_arb_if #(.N_REQ(N), .DATA_W(W)) bus ();

    iob_reg_rr_arb #(
        .N_REQ   (N),
        .DATA_W  (W),
        .RST_VAL (RV),
        .TIMEOUT (TO)
    ) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .rst_i    (rst),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who owns the register, where the search starts next.
    bit         m_owned;
    int         m_owner;
    int         m_ptr;
    int         m_idle;
    logic [7:0] m_data;
    bit         m_upd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owned = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_idle  = 0;
        m_data  = RV;
        m_upd   = 1'b0;
    endtask

    task automatic model_release();
        m_owned = 1'b0;
        m_ptr   = (m_owner + 1) % N;
        m_idle  = 0;
    endtask

    // One clock cycle: drive, compare against the model, clock, advance model.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [N*W-1:0] d, input logic c, input logic r);
        bit xfer;
        bus.req_valid_i = v;
        bus.req_lock_i  = l;
        bus.req_data_i  = d;
        cke = c;
        rst = r;
        #1;
        chk("ready",  32'(bus.req_ready_o), (m_owned && c) ? (32'd1 << m_owner) : 32'd0);
        chk("grant",  32'(bus.grant_idx_o), 32'(m_owner));
        chk("busy",   32'(bus.busy_o),      32'(m_owned));
        chk("data",   32'(bus.data_o),      32'(m_data));
        chk("update", 32'(bus.update_o),    32'(m_upd));
        @(posedge clk);
        if (c) begin
            if (r) begin
                model_reset();
            end else if (!m_owned) begin
                m_upd = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (v[(m_ptr + k) % N]) begin
                        m_owned = 1'b1;
                        m_owner = (m_ptr + k) % N;
                        m_idle  = 0;
                        break;
                    end
                end
            end else begin
                xfer  = v[m_owner];
                m_upd = xfer;
                if (xfer) begin
                    m_data = d[m_owner*W +: W];
                    m_idle = 0;
                    if (!l[m_owner]) model_release();
                end else if (!l[m_owner]) begin
                    model_release();
                end else begin
                    m_idle++;
                    if (TO_EN && m_idle == TO) model_release();
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        bus.req_valid_i = '0;
        bus.req_lock_i  = '0;
        bus.req_data_i  = '0;
        #12;
        chk("rst_data",  32'(bus.data_o),      32'hA5);
        chk("rst_busy",  32'(bus.busy_o),      32'd0);
        chk("rst_grant", 32'(bus.grant_idx_o), 32'd0);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_upd",   32'(bus.update_o),    32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // All four valid, no lock: grants 0,1,2,3 then back to 0.
        for (int i = 0; i < 9; i++) step(4'hF, 4'h0, 32'h40302010, 1'b1, 1'b0);
        chk("rr_data",  32'(bus.data_o),      32'h40);
        chk("rr_grant", 32'(bus.grant_idx_o), 32'd0);
        chk("rr_busy",  32'(bus.busy_o),      32'd1);
        step(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);

        // Move the pointer to 2 with a lone transfer from requester 1.
        step(4'h2, 4'h0, 32'h00005500, 1'b1, 1'b0);
        step(4'h2, 4'h0, 32'h00005500, 1'b1, 1'b0);
        chk("ptr_data", 32'(bus.data_o), 32'h55);

        // Locked burst from requester 2 while requester 1 keeps asking.
        step(4'h6, 4'h4, 32'h00110000, 1'b1, 1'b0);
        step(4'h6, 4'h4, 32'h00110000, 1'b1, 1'b0);
        step(4'h6, 4'h4, 32'h00220000, 1'b1, 1'b0);
        step(4'h6, 4'h0, 32'h00330000, 1'b1, 1'b0);
        chk("lock_data", 32'(bus.data_o),      32'h33);
        chk("lock_busy", 32'(bus.busy_o),      32'd0);
        step(4'h2, 4'h2, 32'h00000000, 1'b1, 1'b0);
        chk("lock_next", 32'(bus.grant_idx_o), 32'd1);

        // Synchronous clear while requester 1 holds a lock.
        step(4'h2, 4'h2, 32'h00009900, 1'b1, 1'b1);
        chk("srst_data", 32'(bus.data_o), 32'hA5);
        chk("srst_busy", 32'(bus.busy_o), 32'd0);
        step(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);

        // Clock enable low for three cycles in the middle of an ownership.
        step(4'h1, 4'h0, 32'h00000077, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'h1, 4'h0, 32'h00000077, 1'b0, 1'b0);
        chk("cke_hold", 32'(bus.data_o), 32'hA5);
        step(4'h1, 4'h0, 32'h00000077, 1'b1, 1'b0);
        chk("cke_data", 32'(bus.data_o), 32'h77);
        chk("cke_upd",  32'(bus.update_o), 32'd1);

        // Locked owner going quiet: held forever, or force-released.
        step(4'h1, 4'h1, 32'h0, 1'b1, 1'b0);
        step(4'h0, 4'h1, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step(4'h0, 4'h1, 32'h0, 1'b1, 1'b0);
        chk("to_busy", 32'(bus.busy_o), TO_EN ? 32'd0 : 32'd1);
        chk("to_data", 32'(bus.data_o), 32'h77);
        step(4'h0, 4'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), N'($urandom), $urandom,
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iob_reg_rr_arb.md
Name: iob_reg_rr_arb

Overview:
Round-robin write arbiter that shares one DATA_W-bit holding register between N_REQ requesters.
- Grants one owner at a time and supports locked multi-cycle ownership.
- Exposes the register value plus an update strobe to downstream logic.
- Used wherever several control agents program a single shared configuration/data register.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 32, register/data width
RST_VAL, 0, register value after reset or rst_i clear
TIMEOUT, 16, max idle cycles a locked owner may hold the grant (only with the optional feature)

Ports:
clk_i  input  1  clock
arst_n_i  input  1  asynchronous reset, active-low
cke_i  input  1  clock enable; 0 freezes all state
rst_i  input  1  synchronous clear, active-high
req_valid_i  input  N_REQ  per-requester write request
req_lock_i  input  N_REQ  per-requester "keep grant after this transfer"
req_data_i  input  N_REQ*DATA_W  packed write data, requester k at [k*DATA_W +: DATA_W]
req_ready_o  output  N_REQ  one-hot; the transfer of requester k is accepted this cycle
grant_idx_o  output  $clog2(N_REQ)  current/last owner index
busy_o  output  1  1 while in OWNED
data_o  output  DATA_W  register contents
update_o  output  1  1-cycle pulse the cycle after data_o changed by a transfer

Behaviour:
- Reset (arst_n_i=0, async): state=IDLE, ptr=0, grant_idx_o=0, data_o=RST_VAL, update_o=0, busy_o=0, req_ready_o=0.
- rst_i=1 with cke_i=1: same values as async reset at the next edge. Has priority over any transfer or state change, including mid-ownership.
- cke_i=0: no state, pointer, counter or register change; req_ready_o forced to 0 so no transfer is taken.
- FSM has two states.
- IDLE:
  - Rotating-priority search over req_valid_i starting at index ptr, wrapping N_REQ-1 -> 0.
  - Winner is latched into grant_idx_o; go to OWNED next edge. Arbitration latency is 1 cycle.
  - No valid: stay IDLE.
  - req_ready_o=0 and busy_o=0 in IDLE.
- OWNED (owner o = grant_idx_o):
  - req_ready_o[o]=cke_i; all other ready bits are 0.
  - Transfer when req_valid_i[o] & req_ready_o[o]: data_o <= slice o at the edge, so data is visible 1 cycle after the handshake; update_o=1 in that following cycle only.
  - Transfer with req_lock_i[o]=1: stay OWNED.
  - Transfer with req_lock_i[o]=0: go IDLE and set ptr <= (o+1) mod N_REQ.
  - No transfer and req_lock_i[o]=0: release without writing; go IDLE and set ptr <= (o+1) mod N_REQ.
  - No transfer and req_lock_i[o]=1: hold OWNED.
- Back-to-back: after release, IDLE re-arbitrates the next cycle, so the per-requester transfer cadence is at most 1 per 2 cycles without lock and 1 per cycle with lock.
- Non-owner valids are ignored (no data change) and remain pending.
- Pointer wraps modulo N_REQ; for non-power-of-2 N_REQ, indices >= N_REQ never occur.

Optional Feature:
IOB_REG_RR_ARB_TIMEOUT_EN
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entering OWNED and on every transfer.
  - It increments each enabled cycle in OWNED without a transfer.
  - When it reaches TIMEOUT, the owner is force-released: go IDLE, ptr <= o+1, no write.
  - Counter is cleared by reset and rst_i.
- Undefined: no counter; a locked owner holds the grant indefinitely; the TIMEOUT parameter is unused.

Decomposition:
- Package iob_reg_rr_arb_pkg holds:
  - state encoding localparams (IDLE=1'b0, OWNED=1'b1);
  - an index-width helper (IDX_W=$clog2(N_REQ), minimum 1).
- Sub-module iob_reg_rr_arb_pick: combinational rotating-priority picker with inputs valid vector and ptr, outputs found and index.
- The data register is an instance of the team's iob_reg_r (sync clear on rst_i), wrapped so that its async reset is driven by ~arst_n_i.

Test Plan (N_REQ=4, DATA_W=8, RST_VAL=8'hA5, TIMEOUT=4):
- Reset: arst_n_i low then high -> data_o=A5, busy_o=0, grant_idx_o=0, req_ready_o=0000.
- All four requesters valid, lock=0, data 10/20/30/40 -> grants in order 0,1,2,3,0; data_o sequence 10,20,30,40; one update_o pulse each.
- Requester 2 with lock=1 sends 3 words (11,22,33), lock=0 on the last -> ready stays on bit 2 for 3 cycles; data_o=33; ptr=3; requester 1, valid throughout, is not granted until the release.
- rst_i=1 while OWNED by 1 with lock=1 -> next edge: IDLE, data_o=A5, ptr=0, no update_o pulse.
- cke_i=0 for 3 cycles while OWNED with valid=1 -> req_ready_o=0, data_o unchanged; the transfer completes after cke_i returns.
- With IOB_REG_RR_ARB_TIMEOUT_EN: owner 0, lock=1, valid=0 for 4 cycles -> forced to IDLE, ptr=1, data_o unchanged. Without the macro -> still OWNED after 20 cycles.
